// File: rtl/codec_audio_timer_pkg.sv
// Shared definitions for the CodecAudio multi-channel interval timer.
//   - per-channel register offsets (word address bits [2:0])
//   - CONTROL register bit positions
//   - packed structs for the CONTROL and STATUS state held per channel
package codec_audio_timer_pkg;

   localparam logic [2:0] OFS_STATUS   = 3'd0;
   localparam logic [2:0] OFS_CONTROL  = 3'd1;
   localparam logic [2:0] OFS_PERIOD_L = 3'd2;
   localparam logic [2:0] OFS_PERIOD_H = 3'd3;
   localparam logic [2:0] OFS_SNAP_L   = 3'd4;
   localparam logic [2:0] OFS_SNAP_H   = 3'd5;
   localparam logic [2:0] OFS_PRESCALE = 3'd6;

   localparam int unsigned CTRL_ITO    = 0;
   localparam int unsigned CTRL_CONT   = 1;
   localparam int unsigned CTRL_START  = 2;
   localparam int unsigned CTRL_STOP   = 3;
   localparam int unsigned CTRL_TOG_EN = 4;

   // Only the stored CONTROL bits; START/STOP are strobes and never held.
   typedef struct packed {
      logic tog_en;
      logic cont;
      logic ito;
   } ctrl_t;

   typedef struct packed {
      logic run;
      logic to;
   } status_t;

endpackage

// File: rtl/codec_audio_multi_timer_if.sv
// Avalon-MM slave bus of the multi-channel timer (16-bit data, word addressed).
//   address     word address: [ADDR_W-1:3] channel, [2:0] register offset
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data (one cycle latency)
interface codec_audio_multi_timer_if #(
   parameter int unsigned ADDR_W = 4
) ();

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [15:0]       writedata;
   logic [15:0]       readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/codec_audio_timer_channel.sv
// One timer channel: prescaler, down-counter, period, snapshot, control/status
// and toggle output.
//   clk, reset_n  clock and asynchronous active-low reset
//   wr_en         write strobe already qualified with this channel's select
//   ofs           register offset (shared by write and read)
//   wdata         write data
//   rdata         combinational read data for offset ofs
//   irq           TO & ITO
//   tog           toggle output
module codec_audio_timer_channel
   import codec_audio_timer_pkg::*;
#(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned PRE_W        = 16,
   parameter int unsigned RESET_PERIOD = 99
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [2:0]  ofs,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        irq,
   output logic        tog
);

   localparam int unsigned HI_W = CNT_W - 16;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] snap_q, snap_d;
   logic [PRE_W-1:0] pcnt_q, pcnt_d;
   logic [PRE_W-1:0] prescale_q, prescale_d;
   ctrl_t            ctrl_q, ctrl_d;
   status_t          status_q, status_d;
   logic             tog_q, tog_d;
   logic             force_reload_q, force_reload_d;

   logic tick, timeout;
   logic wr_status, wr_ctrl, wr_period_l, wr_period_h, wr_snap, wr_prescale;

   assign tick    = status_q.run & (pcnt_q == '0);
   assign timeout = tick & (cnt_q == '0);

   assign wr_status   = wr_en && (ofs == OFS_STATUS);
   assign wr_ctrl     = wr_en && (ofs == OFS_CONTROL);
   assign wr_period_l = wr_en && (ofs == OFS_PERIOD_L);
   assign wr_period_h = wr_en && (ofs == OFS_PERIOD_H);
   assign wr_snap     = wr_en && ((ofs == OFS_SNAP_L) || (ofs == OFS_SNAP_H));
   assign wr_prescale = wr_en && (ofs == OFS_PRESCALE);

   always_comb begin
      cnt_d          = cnt_q;
      period_d       = period_q;
      snap_d         = snap_q;
      pcnt_d         = pcnt_q;
      prescale_d     = prescale_q;
      ctrl_d         = ctrl_q;
      status_d       = status_q;
      tog_d          = tog_q;
      force_reload_d = wr_period_l | wr_period_h;

      if (wr_period_l) period_d[15:0]       = wdata;
      if (wr_period_h) period_d[CNT_W-1:16] = wdata[HI_W-1:0];
      if (wr_prescale) prescale_d           = wdata[PRE_W-1:0];
      // Snapshot samples the counter before this cycle's update.
      if (wr_snap)     snap_d               = cnt_q;
      if (wr_ctrl) begin
         ctrl_d.tog_en = wdata[CTRL_TOG_EN];
         ctrl_d.cont   = wdata[CTRL_CONT];
         ctrl_d.ito    = wdata[CTRL_ITO];
      end

      if (tick) begin
         pcnt_d = prescale_q;
         cnt_d  = (cnt_q == '0) ? period_q : cnt_q - 1'b1;
      end else if (status_q.run) begin
         pcnt_d = pcnt_q - 1'b1;
      end

      // RUN priority, lowest first: one-shot expiry, STOP, START, force reload.
      if (timeout && !ctrl_q.cont)        status_d.run = 1'b0;
      if (wr_ctrl && wdata[CTRL_STOP])    status_d.run = 1'b0;
      if (wr_ctrl && wdata[CTRL_START])   status_d.run = 1'b1;
      if (force_reload_q) begin
         cnt_d        = period_q;
         pcnt_d       = prescale_q;
         status_d.run = 1'b0;
      end

      // Set beats clear so a timeout coinciding with an acknowledge is kept.
      if (wr_status) status_d.to = 1'b0;
      if (timeout)   status_d.to = 1'b1;

      if (timeout && ctrl_q.tog_en) tog_d = ~tog_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q          <= CNT_W'(RESET_PERIOD);
         period_q       <= CNT_W'(RESET_PERIOD);
         snap_q         <= '0;
         pcnt_q         <= '0;
         prescale_q     <= '0;
         ctrl_q         <= '0;
         status_q       <= '0;
         tog_q          <= 1'b0;
         force_reload_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         snap_q         <= snap_d;
         pcnt_q         <= pcnt_d;
         prescale_q     <= prescale_d;
         ctrl_q         <= ctrl_d;
         status_q       <= status_d;
         tog_q          <= tog_d;
         force_reload_q <= force_reload_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (ofs)
         OFS_STATUS:   rdata = {14'd0, status_q.run, status_q.to};
         OFS_CONTROL:  rdata = {11'd0, ctrl_q.tog_en, 2'b00, ctrl_q.cont, ctrl_q.ito};
         OFS_PERIOD_L: rdata = period_q[15:0];
         OFS_PERIOD_H: rdata = 16'(period_q[CNT_W-1:16]);
         OFS_SNAP_L:   rdata = snap_q[15:0];
         OFS_SNAP_H:   rdata = 16'(snap_q[CNT_W-1:16]);
         OFS_PRESCALE: rdata = 16'(prescale_q);
         default:      rdata = '0;
      endcase
   end

   assign irq = status_q.to & ctrl_q.ito;
   assign tog = tog_q;

endmodule

// File: rtl/codec_audio_multi_timer.sv
// Multi-channel interval timer for the CodecAudio system: NUM_CH independent
// prescaled down-counters behind one 16-bit Avalon-MM slave.
//   clk, reset_n  clock and asynchronous active-low reset
//   avs           Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   irq           OR over channels of (TO & ITO)
//   tog_out       per-channel toggle outputs
module codec_audio_multi_timer
   import codec_audio_timer_pkg::*;
#(
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned PRE_W        = 16,
   parameter int unsigned RESET_PERIOD = 99,
   parameter int unsigned ADDR_W       = ((3 + $clog2(NUM_CH)) < 4) ? 4 : 3 + $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   codec_audio_multi_timer_if.slave avs,
   output logic                    irq,
   output logic [NUM_CH-1:0]       tog_out
);

   localparam int unsigned CH_W = ADDR_W - 3;

   logic [CH_W-1:0]   ch_sel;
   logic [2:0]        ofs;
   logic              wr;
   logic [NUM_CH-1:0] ch_wr;
   logic [NUM_CH-1:0] ch_irq;
   logic [15:0]       ch_rdata [NUM_CH];
   logic [15:0]       rdata_mux;
   logic [15:0]       readdata_q;

   assign ch_sel = avs.address[ADDR_W-1:3];
   assign ofs    = avs.address[2:0];
   assign wr     = avs.chipselect & ~avs.write_n;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_wr[i] = wr && (ch_sel == CH_W'(i));

      codec_audio_timer_channel #(
         .CNT_W        (CNT_W),
         .PRE_W        (PRE_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .wr_en   (ch_wr[i]),
         .ofs     (ofs),
         .wdata   (avs.writedata),
         .rdata   (ch_rdata[i]),
         .irq     (ch_irq[i]),
         .tog     (tog_out[i])
      );
   end

   // Unpopulated channel indices fall through to zero.
   always_comb begin
      rdata_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == CH_W'(i)) rdata_mux = ch_rdata[i];
      end
   end

   // Read data tracks the address every cycle, independent of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata_q <= '0;
      else          readdata_q <= rdata_mux;
   end

   assign avs.readdata = readdata_q;
   assign irq          = |ch_irq;

endmodule
